te_round_scheduler: RTL and testbench
=====================================

Name: te_round_scheduler

Overview:
- Sequences one tracking-engine round across all enabled logical channels (max 32).
- Each batch: picks up to 4 enabled logical channels and binds them to physical slots 0..3, then runs fill, correlation and dump in that order.
- Drives the fill/dump state controller through fill_start/dump_start and physical_channel_en/logic_channel_index0..3, and the correlator through corr_start.
- Sits between the tracking-engine register block and the fill/dump controller and correlator.

Parameters:
- WAIT_TIMEOUT, 1023, max cycles spent in any *_WAIT state before the round aborts with an error (10-bit counter).

Ports:
- clk  input  1  system clock
- rst_b  input  1  reset; synchronous, active-low
- te_start  input  1  round start pulse; ignored while busy
- te_abort  input  1  synchronous abort of the current round
- channel_mask  input  32  logical channel enables; sampled only on an accepted te_start
- fill_state_done  input  1  1-cycle pulse from the fill/dump controller
- dump_state_done  input  1  1-cycle pulse from the fill/dump controller
- corr_done  input  1  1-cycle pulse from the correlator
- physical_channel_en  output  4  slot valid bits for the current batch
- logic_channel_index0  output  5  logical channel bound to slot 0
- logic_channel_index1  output  5  logical channel bound to slot 1
- logic_channel_index2  output  5  logical channel bound to slot 2
- logic_channel_index3  output  5  logical channel bound to slot 3
- fill_start  output  1  1-cycle pulse
- corr_start  output  1  1-cycle pulse
- dump_start  output  1  1-cycle pulse
- round_done  output  1  1-cycle pulse at normal round completion
- busy  output  1  high whenever state != IDLE
- timeout_err  output  1  sticky; cleared only by an accepted te_start or by reset

Behaviour:
- Reset (rst_b low at a clk edge):
  - State IDLE.
  - All outputs 0, including all indices and timeout_err.
  - Remaining mask 0, slot pointer 0, timeout counter 0.
- States: IDLE, FIND, FILL_REQ, FILL_WAIT, CORR_REQ, CORR_WAIT, DUMP_REQ, DUMP_WAIT, DONE.
- IDLE:
  - te_start=1: latch channel_mask into the remaining mask, clear timeout_err, go to FIND.
  - A zero mask still goes to FIND.
- FIND entry from IDLE or DUMP_WAIT: physical_channel_en <= 0, slot pointer k <= 0 in the same cycle.
- FIND, one channel per cycle:
  - If remaining != 0: take its lowest set bit index i; logic_channel_indexk <= i; physical_channel_en[k] <= 1; clear bit i from remaining; k++.
  - Exit to FILL_REQ once 4 slots are taken or the updated remaining is 0.
  - If remaining == 0 and k == 0 on entry: go to DONE with no fill/corr/dump.
  - Latency to bind 4 channels: 4 FIND cycles.
- FILL_REQ: fill_start=1 for exactly one cycle, then FILL_WAIT.
- FILL_WAIT: on fill_state_done go to CORR_REQ.
- CORR_REQ: corr_start=1 for exactly one cycle, then CORR_WAIT.
- CORR_WAIT: on corr_done go to DUMP_REQ.
- DUMP_REQ: dump_start=1 for exactly one cycle, then DUMP_WAIT.
- DUMP_WAIT: on dump_state_done, go to FIND if remaining != 0, else DONE.
- DONE: round_done=1 for one cycle, then IDLE.
- Slot bindings:
  - physical_channel_en and logic_channel_indexN hold stable from FIND exit until the next FIND entry.
  - Unused slot indices keep stale values; their en bit is 0.
- Done pulses:
  - Done pulses arriving outside the matching WAIT state are ignored.
  - A done pulse in the same cycle as entering its WAIT state is not possible, because the REQ state takes one cycle.
- Timeout:
  - Counter clears on entry to each WAIT state and increments in WAIT.
  - Reaching WAIT_TIMEOUT without the expected done: timeout_err <= 1, physical_channel_en <= 0, go to IDLE with no round_done.
- te_abort:
  - Any non-IDLE state: next state IDLE, physical_channel_en <= 0, remaining <= 0, no round_done, timeout_err unchanged.
  - Higher priority than done pulses and timeout in the same cycle.
  - In IDLE, te_abort has no effect and takes priority over a simultaneous te_start (start dropped).
- te_start while busy is ignored; channel_mask changes mid-round have no effect.
- Mid-round rst_b low returns to the reset state on the next edge; no pulses are emitted.

Test Plan:
- Mask 32'h0000_0005, te_start, done pulses returned 3 cycles after each start:
  - slots 0/1 bound to channels 0/2; physical_channel_en=4'b0011.
  - One fill_start, one corr_start, one dump_start, in that order.
  - round_done 1 cycle after dump_state_done; busy low the cycle after round_done.
- Mask 32'hFFFF_FFFF: 8 batches, each with physical_channel_en=4'b1111.
  - Batch 0 indices 0,1,2,3; batch 7 indices 28..31.
  - Exactly 8 pulses each of fill_start, corr_start and dump_start; one round_done.
- Mask 32'h8000_0021 (channels 0, 5, 31): single batch with en=4'b0111, indices 0,5,31.
  - Mask 32'h0: round_done 2 cycles after te_start (FIND, DONE) and no fill_start.
- Withhold corr_done with WAIT_TIMEOUT=15:
  - timeout_err rises after 15 CORR_WAIT cycles; state IDLE; no round_done.
  - Next te_start clears timeout_err.
- te_abort in FILL_WAIT while fill_state_done is also asserted:
  - IDLE next cycle, en=0, no corr_start, no round_done.
  - A second te_start during busy produces no effect.
- rst_b low for 1 cycle during DUMP_WAIT: all outputs 0 next cycle; a later dump_state_done is ignored.

Source files
------------

// File: rtl/te_round_scheduler.sv
// Tracking-engine round scheduler.
// Walks the enabled logical channels of one round in batches of up to four,
// binds each batch to physical slots 0..3 and sequences fill, correlation and
// dump for it. Any WAIT state that outlasts WAIT_TIMEOUT cycles aborts the
// round and raises a sticky timeout_err.
module te_round_scheduler #(
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        te_start,
    input  logic        te_abort,
    input  logic [31:0] channel_mask,
    input  logic        fill_state_done,
    input  logic        dump_state_done,
    input  logic        corr_done,
    output logic [3:0]  physical_channel_en,
    output logic [4:0]  logic_channel_index0,
    output logic [4:0]  logic_channel_index1,
    output logic [4:0]  logic_channel_index2,
    output logic [4:0]  logic_channel_index3,
    output logic        fill_start,
    output logic        corr_start,
    output logic        dump_start,
    output logic        round_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE,
        FIND,
        FILL_REQ,
        FILL_WAIT,
        CORR_REQ,
        CORR_WAIT,
        DUMP_REQ,
        DUMP_WAIT,
        DONE
    } state_t;

    // Last wait_cnt value before giving up: the counter starts at 0 on WAIT
    // entry, so this value is reached in the WAIT_TIMEOUT-th WAIT cycle.
    localparam logic [9:0] WAIT_LAST = 10'(WAIT_TIMEOUT - 1);

    state_t      state;
    logic [31:0] remaining;
    logic [1:0]  slot_k;
    logic [9:0]  wait_cnt;
    logic [4:0]  slot_idx [4];
    logic [4:0]  low_idx;
    logic [31:0] rem_next;
    logic        wait_done;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    assign logic_channel_index0 = slot_idx[0];
    assign logic_channel_index1 = slot_idx[1];
    assign logic_channel_index2 = slot_idx[2];
    assign logic_channel_index3 = slot_idx[3];

    // Next channel to bind and the remaining mask once it has been taken.
    always_comb begin
        low_idx  = lowest_set(remaining);
        rem_next = remaining & ~(32'd1 << low_idx);
    end

    // Completion pulse that matters in the current WAIT state; others are ignored.
    always_comb begin
        wait_done = 1'b0;
        case (state)
            FILL_WAIT: wait_done = fill_state_done;
            CORR_WAIT: wait_done = corr_done;
            DUMP_WAIT: wait_done = dump_state_done;
            default:   wait_done = 1'b0;
        endcase
    end

    // Round sequencer with registered outputs; abort outranks done and timeout.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state               <= IDLE;
            remaining           <= '0;
            slot_k              <= '0;
            wait_cnt            <= '0;
            physical_channel_en <= '0;
            for (int s = 0; s < 4; s++) slot_idx[s] <= '0;
            fill_start          <= 1'b0;
            corr_start          <= 1'b0;
            dump_start          <= 1'b0;
            round_done          <= 1'b0;
            busy                <= 1'b0;
            timeout_err         <= 1'b0;
        end else begin
            fill_start <= 1'b0;
            corr_start <= 1'b0;
            dump_start <= 1'b0;
            round_done <= 1'b0;
            if (te_abort) begin
                if (state != IDLE) begin
                    state               <= IDLE;
                    busy                <= 1'b0;
                    physical_channel_en <= '0;
                    remaining           <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (te_start) begin
                            remaining           <= channel_mask;
                            timeout_err         <= 1'b0;
                            physical_channel_en <= '0;
                            slot_k              <= '0;
                            busy                <= 1'b1;
                            state               <= FIND;
                        end
                    end
                    FIND: begin
                        if (remaining != '0) begin
                            slot_idx[slot_k]            <= low_idx;
                            physical_channel_en[slot_k] <= 1'b1;
                            remaining                   <= rem_next;
                            slot_k                      <= slot_k + 2'd1;
                            if (slot_k == 2'd3 || rem_next == '0) begin
                                state      <= FILL_REQ;
                                fill_start <= 1'b1;
                            end
                        end else begin
                            state      <= DONE;
                            round_done <= 1'b1;
                        end
                    end
                    FILL_REQ: begin
                        state    <= FILL_WAIT;
                        wait_cnt <= '0;
                    end
                    CORR_REQ: begin
                        state    <= CORR_WAIT;
                        wait_cnt <= '0;
                    end
                    DUMP_REQ: begin
                        state    <= DUMP_WAIT;
                        wait_cnt <= '0;
                    end
                    FILL_WAIT, CORR_WAIT, DUMP_WAIT: begin
                        if (wait_done) begin
                            if (state == FILL_WAIT) begin
                                state      <= CORR_REQ;
                                corr_start <= 1'b1;
                            end else if (state == CORR_WAIT) begin
                                state      <= DUMP_REQ;
                                dump_start <= 1'b1;
                            end else if (remaining != '0) begin
                                state               <= FIND;
                                physical_channel_en <= '0;
                                slot_k              <= '0;
                            end else begin
                                state      <= DONE;
                                round_done <= 1'b1;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            timeout_err         <= 1'b1;
                            physical_channel_en <= '0;
                            busy                <= 1'b0;
                            state               <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 10'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_te_round_scheduler.sv
// Testbench for te_round_scheduler: randomized rounds against a batch model
// derived from the channel mask, plus directed timeout, abort and reset cases.
module tb_te_round_scheduler;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        te_start;
    logic        te_abort;
    logic [31:0] channel_mask;
    logic        fill_state_done;
    logic        dump_state_done;
    logic        corr_done;
    logic [3:0]  physical_channel_en;
    logic [4:0]  logic_channel_index0;
    logic [4:0]  logic_channel_index1;
    logic [4:0]  logic_channel_index2;
    logic [4:0]  logic_channel_index3;
    logic        fill_start;
    logic        corr_start;
    logic        dump_start;
    logic        round_done;
    logic        busy;
    logic        timeout_err;

    te_round_scheduler #(.WAIT_TIMEOUT(15)) dut (
        .clk                  (clk),
        .rst_b                (rst_b),
        .te_start             (te_start),
        .te_abort             (te_abort),
        .channel_mask         (channel_mask),
        .fill_state_done      (fill_state_done),
        .dump_state_done      (dump_state_done),
        .corr_done            (corr_done),
        .physical_channel_en  (physical_channel_en),
        .logic_channel_index0 (logic_channel_index0),
        .logic_channel_index1 (logic_channel_index1),
        .logic_channel_index2 (logic_channel_index2),
        .logic_channel_index3 (logic_channel_index3),
        .fill_start           (fill_start),
        .corr_start           (corr_start),
        .dump_start           (dump_start),
        .round_done           (round_done),
        .busy                 (busy),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Observations collected by run_round
    int         n_fill, n_corr, n_dump, n_done;
    int         seq_q[$];
    logic [3:0] ben_q[$];
    logic [4:0] bidx_q[$];
    int         done_cyc, idle_cyc, last_ddone_cyc, corr_cyc, to_cyc, first_fill_cyc;
    bit         hung;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] all_outs();
        return {busy, physical_channel_en, logic_channel_index0, logic_channel_index1,
                logic_channel_index2, logic_channel_index3, fill_start, corr_start,
                dump_start, round_done, timeout_err};
    endfunction

    // Starts one round and plays the fill/dump controller and correlator.
    // Cycle 0 is the first cycle after the te_start edge.
    task automatic run_round(input logic [31:0] mask, input int dmin, input int dmax,
                             input bit noise, input bit withhold_corr);
        int fill_due, corr_due, dump_due, pending;
        n_fill = 0; n_corr = 0; n_dump = 0; n_done = 0;
        seq_q.delete(); ben_q.delete(); bidx_q.delete();
        done_cyc = -1; idle_cyc = -1; last_ddone_cyc = -1; corr_cyc = -1;
        to_cyc = -1; first_fill_cyc = -1; hung = 1'b1;
        fill_due = -1; corr_due = -1; dump_due = -1; pending = 0;
        channel_mask = mask;
        te_start = 1'b1;
        tick();
        te_start = 1'b0;
        channel_mask = $urandom;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (fill_start) begin
                n_fill++;
                seq_q.push_back(1);
                if (first_fill_cyc < 0) first_fill_cyc = cyc;
                ben_q.push_back(physical_channel_en);
                bidx_q.push_back(logic_channel_index0);
                bidx_q.push_back(logic_channel_index1);
                bidx_q.push_back(logic_channel_index2);
                bidx_q.push_back(logic_channel_index3);
                fill_due = cyc + int'($urandom_range(dmax, dmin));
                pending = 1;
            end
            if (corr_start) begin
                n_corr++;
                seq_q.push_back(2);
                corr_cyc = cyc;
                if (!withhold_corr) corr_due = cyc + int'($urandom_range(dmax, dmin));
                pending = 2;
            end
            if (dump_start) begin
                n_dump++;
                seq_q.push_back(3);
                dump_due = cyc + int'($urandom_range(dmax, dmin));
                pending = 3;
            end
            if (round_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (timeout_err && to_cyc < 0) to_cyc = cyc;
            if (!busy) begin
                idle_cyc = cyc;
                hung = 1'b0;
                break;
            end
            fill_state_done = (cyc == fill_due) || (noise && pending != 1 && $urandom_range(4, 0) == 0);
            corr_done       = (cyc == corr_due) || (noise && pending != 2 && $urandom_range(4, 0) == 0);
            dump_state_done = (cyc == dump_due) || (noise && pending != 3 && $urandom_range(4, 0) == 0);
            te_start        = noise && $urandom_range(9, 0) == 0;
            if (te_start) channel_mask = $urandom;
            if (cyc == dump_due) last_ddone_cyc = cyc;
            if (cyc == fill_due || cyc == corr_due || cyc == dump_due) pending = 0;
            tick();
        end
        te_start = 1'b0;
        fill_state_done = 1'b0;
        corr_done = 1'b0;
        dump_state_done = 1'b0;
    endtask

    task automatic wait_out(input int which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ((which == 1 && fill_start) || (which == 2 && corr_start) || (which == 3 && dump_start)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) tick();
        n_checks++; if (all_outs() !== 30'd0) $display("FAIL reset_outputs: got %0h expected 0", all_outs()); else n_pass++;
        rst_b = 1'b1;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (all_outs() !== 30'd0) $display("FAIL reset_idle_outputs: got %0h expected 0", all_outs()); else n_pass++;
    endtask

    task automatic test_two_channels();
        run_round(32'h0000_0005, 3, 3, 1'b0, 1'b0);
        n_checks++; if (hung !== 1'b0) $display("FAIL two_hung: got %0b expected 0", hung); else n_pass++;
        n_checks++; if (ben_q.size() !== 1) $display("FAIL two_batches: got %0d expected 1", ben_q.size()); else n_pass++;
        if (ben_q.size() == 1) begin
            n_checks++; if (ben_q[0] !== 4'b0011) $display("FAIL two_en: got %b expected 0011", ben_q[0]); else n_pass++;
            n_checks++; if (bidx_q[0] !== 5'd0) $display("FAIL two_idx0: got %0d expected 0", bidx_q[0]); else n_pass++;
            n_checks++; if (bidx_q[1] !== 5'd2) $display("FAIL two_idx1: got %0d expected 2", bidx_q[1]); else n_pass++;
        end
        n_checks++; if (seq_q.size() !== 3) $display("FAIL two_seq_len: got %0d expected 3", seq_q.size()); else n_pass++;
        if (seq_q.size() == 3) begin
            n_checks++; if (seq_q[0] !== 1 || seq_q[1] !== 2 || seq_q[2] !== 3)
                $display("FAIL two_seq_order: got %0d%0d%0d expected 123", seq_q[0], seq_q[1], seq_q[2]); else n_pass++;
        end
        n_checks++; if (first_fill_cyc !== 2) $display("FAIL two_fill_cycle: got %0d expected 2", first_fill_cyc); else n_pass++;
        n_checks++; if (done_cyc !== last_ddone_cyc + 1) $display("FAIL two_done_cycle: got %0d expected %0d", done_cyc, last_ddone_cyc + 1); else n_pass++;
        n_checks++; if (idle_cyc !== done_cyc + 1) $display("FAIL two_idle_cycle: got %0d expected %0d", idle_cyc, done_cyc + 1); else n_pass++;
    endtask

    task automatic test_mask_rounds();
        logic [31:0] masks[$];
        masks = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0021, 32'h0000_0000};
        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0:       masks.push_back($urandom);
                1:       masks.push_back($urandom & $urandom & $urandom);
                default: masks.push_back($urandom | $urandom);
            endcase
        end
        foreach (masks[m]) begin
            logic [31:0] mk;
            int bits[$];
            int nb, seq_bad, cnt;
            mk = masks[m];
            for (int i = 0; i < 32; i++) if (mk[i]) bits.push_back(i);
            nb = (bits.size() + 3) / 4;
            run_round(mk, 1, 6, 1'b1, 1'b0);
            n_checks++; if (hung !== 1'b0) $display("FAIL mask_hung %h: got %0b expected 0", mk, hung); else n_pass++;
            n_checks++; if (n_done !== 1) $display("FAIL mask_round_done %h: got %0d expected 1", mk, n_done); else n_pass++;
            n_checks++; if (n_fill !== nb || n_corr !== nb || n_dump !== nb)
                $display("FAIL mask_pulse_counts %h: got %0d/%0d/%0d expected %0d each", mk, n_fill, n_corr, n_dump, nb); else n_pass++;
            seq_bad = 0;
            foreach (seq_q[j]) if (seq_q[j] != (j % 3) + 1) seq_bad++;
            n_checks++; if (seq_bad !== 0) $display("FAIL mask_order %h: got %0d out-of-order pulses expected 0", mk, seq_bad); else n_pass++;
            for (int b = 0; b < nb && b < ben_q.size(); b++) begin
                cnt = (bits.size() - 4 * b > 4) ? 4 : bits.size() - 4 * b;
                n_checks++; if (ben_q[b] !== 4'((1 << cnt) - 1))
                    $display("FAIL mask_en %h batch %0d: got %b expected %b", mk, b, ben_q[b], 4'((1 << cnt) - 1)); else n_pass++;
                for (int s = 0; s < cnt; s++) begin
                    n_checks++; if (bidx_q[4 * b + s] !== 5'(bits[4 * b + s]))
                        $display("FAIL mask_idx %h batch %0d slot %0d: got %0d expected %0d", mk, b, s, bidx_q[4 * b + s], bits[4 * b + s]); else n_pass++;
                end
            end
            if (nb == 0) begin
                n_checks++; if (done_cyc !== 1) $display("FAIL zero_mask_done_cycle: got %0d expected 1", done_cyc); else n_pass++;
            end else begin
                n_checks++; if (first_fill_cyc !== ((bits.size() > 4) ? 4 : bits.size()))
                    $display("FAIL mask_bind_latency %h: got %0d expected %0d", mk, first_fill_cyc, (bits.size() > 4) ? 4 : bits.size()); else n_pass++;
                n_checks++; if (done_cyc !== last_ddone_cyc + 1)
                    $display("FAIL mask_done_cycle %h: got %0d expected %0d", mk, done_cyc, last_ddone_cyc + 1); else n_pass++;
            end
            n_checks++; if (idle_cyc !== done_cyc + 1) $display("FAIL mask_idle_cycle %h: got %0d expected %0d", mk, idle_cyc, done_cyc + 1); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        run_round($urandom | 32'h1, 2, 4, 1'b1, 1'b1);
        n_checks++; if (hung !== 1'b0) $display("FAIL to_hung: got %0b expected 0", hung); else n_pass++;
        // CORR_REQ at corr_cyc, then 15 CORR_WAIT cycles, then IDLE with the flag set.
        n_checks++; if (to_cyc !== corr_cyc + 16) $display("FAIL to_err_cycle: got %0d expected %0d", to_cyc, corr_cyc + 16); else n_pass++;
        n_checks++; if (idle_cyc !== corr_cyc + 16) $display("FAIL to_idle_cycle: got %0d expected %0d", idle_cyc, corr_cyc + 16); else n_pass++;
        n_checks++; if (n_done !== 0 || n_dump !== 0) $display("FAIL to_no_done: got done=%0d dump=%0d expected 0/0", n_done, n_dump); else n_pass++;
        n_checks++; if (physical_channel_en !== 4'b0) $display("FAIL to_en: got %b expected 0000", physical_channel_en); else n_pass++;
        te_abort = 1'b1;
        te_start = 1'b1;
        channel_mask = 32'h0000_000F;
        tick();
        te_abort = 1'b0;
        te_start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_abort_start_busy: got %0b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL idle_abort_keeps_err: got %0b expected 1", timeout_err); else n_pass++;
        run_round(32'h0, 1, 3, 1'b0, 1'b0);
        n_checks++; if (to_cyc !== -1 || timeout_err !== 1'b0)
            $display("FAIL to_cleared_by_start: got first_err_cycle=%0d err=%0b expected -1/0", to_cyc, timeout_err); else n_pass++;
        n_checks++; if (n_done !== 1) $display("FAIL to_next_round_done: got %0d expected 1", n_done); else n_pass++;
    endtask

    task automatic test_abort();
        bit seen, saw_corr, saw_done, saw_busy;
        channel_mask = $urandom | 32'h1;
        te_start = 1'b1;
        tick();
        te_start = 1'b0;
        wait_out(1, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL abort_fill_start: got %0b expected 1", seen); else n_pass++;
        repeat (2) tick();
        te_abort = 1'b1;
        fill_state_done = 1'b1;
        tick();
        te_abort = 1'b0;
        fill_state_done = 1'b0;
        n_checks++; if (busy !== 1'b0 || physical_channel_en !== 4'b0)
            $display("FAIL abort_idle: got busy=%0b en=%b expected 0/0000", busy, physical_channel_en); else n_pass++;
        saw_corr = corr_start;
        saw_done = round_done;
        saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            corr_done = $urandom_range(1, 0) == 1;
            dump_state_done = $urandom_range(1, 0) == 1;
            tick();
            saw_corr |= corr_start;
            saw_done |= round_done;
            saw_busy |= busy;
        end
        corr_done = 1'b0;
        dump_state_done = 1'b0;
        n_checks++; if (saw_corr || saw_done || saw_busy)
            $display("FAIL abort_quiet: got corr=%0b done=%0b busy=%0b expected 0/0/0", saw_corr, saw_done, saw_busy); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL abort_err: got %0b expected 0", timeout_err); else n_pass++;
    endtask

    task automatic test_reset_mid_round();
        bit seen, saw_any;
        channel_mask = 32'h0000_0F0F;
        te_start = 1'b1;
        tick();
        te_start = 1'b0;
        wait_out(1, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL rst_mid_fill: got %0b expected 1", seen); else n_pass++;
        repeat (2) tick();
        fill_state_done = 1'b1;
        tick();
        fill_state_done = 1'b0;
        wait_out(2, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL rst_mid_corr: got %0b expected 1", seen); else n_pass++;
        tick();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        wait_out(3, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL rst_mid_dump: got %0b expected 1", seen); else n_pass++;
        tick();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        n_checks++; if (all_outs() !== 30'd0) $display("FAIL rst_mid_outputs: got %0h expected 0", all_outs()); else n_pass++;
        dump_state_done = 1'b1;
        tick();
        dump_state_done = 1'b0;
        saw_any = (all_outs() != 30'd0);
        repeat (6) begin
            tick();
            saw_any |= (all_outs() != 30'd0);
        end
        n_checks++; if (saw_any !== 1'b0) $display("FAIL rst_mid_dump_ignored: got activity=%0b expected 0", saw_any); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_b = 1'b0;
        te_start = 1'b0;
        te_abort = 1'b0;
        channel_mask = '0;
        fill_state_done = 1'b0;
        dump_state_done = 1'b0;
        corr_done = 1'b0;
        test_reset();
        test_two_channels();
        test_mask_rounds();
        test_timeout();
        test_abort();
        test_reset_mid_round();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
